rv32i_alu_decode_stage: RTL and testbench
=========================================

Name: rv32i_alu_decode_stage

Overview:
- Registered decode stage that produces the operation stream consumed by the RV32I ALU.
- Takes fetched instructions and PC over a valid/ready handshake, decodes ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) and emits one pipeline register of EX-stage controls.
- Outputs are: 4-bit ALU operation code, register indices, sign-extended immediate and operand-select flags.
- Sits between fetch and execute; supports back-pressure from EX and a flush from branch/exception logic.

Parameters:
- XLEN, 32, datapath/PC/immediate width (only 32 is supported).
- RESET_PC_TAG, 32'h0000_0000, value of out_pc while the stage is empty/reset.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill held and incoming instruction this cycle.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage accepts this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  PC of in_instr.
- out_valid  output  1  EX payload valid.
- out_ready  input  1  EX accepts payload.
- out_alu_control  output  4  ALU operation code (see package).
- out_rs1  output  5  source register 1 index (forced 0 for LUI/AUIPC).
- out_rs2  output  5  source register 2 index (0 for immediate forms).
- out_rd  output  5  destination register.
- out_imm  output  XLEN  decoded immediate.
- out_use_imm  output  1  ALU b operand = out_imm.
- out_use_pc  output  1  ALU a operand = out_pc (AUIPC).
- out_reg_write  output  1  write rd; 0 when rd==0 or illegal.
- out_pc  output  XLEN  registered PC.
- out_illegal  output  1  instruction not an encodable ALU-class op.

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid=0, out_alu_control=4'b0000, out_rs1/rs2/rd=0, out_imm=0.
  - out_use_imm=0, out_use_pc=0, out_reg_write=0, out_illegal=0, out_pc=RESET_PC_TAG.
  - Reset overrides flush and any handshake; an in-flight payload is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - Accept when in_valid && in_ready: the payload registers at that edge.
  - Latency is 1 cycle from acceptance to out_valid.
  - Throughput is 1/cycle while out_ready=1.
- Stall: out_valid && !out_ready holds every out_* field stable until accepted.
- Empty: out_valid=0 and no accept leaves the payload fields unchanged; they are don't-care while invalid.
- Flush:
  - Next edge forces out_valid=0.
  - in_ready stays per formula, but an instruction presented in the flush cycle is dropped, not captured.
- ALU operation codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- OP (0110011), by funct3/funct7:
  - 000/0000000 ADD; 000/0100000 SUB.
  - 001/0000000 SLL; 010/0000000 SLT; 011/0000000 SLTU; 100/0000000 XOR.
  - 101/0000000 SRL; 101/0100000 SRA; 110/0000000 OR; 111/0000000 AND.
  - Any other funct7 -> illegal.
- OP-IMM (0010011):
  - I-immediate sign-extended from bit 31; out_use_imm=1, out_rs2=0.
  - funct3 000 ADD, 010 SLT, 011 SLTU (sign-extended imm, unsigned compare is done in the ALU), 100 XOR, 110 OR, 111 AND.
  - 001 needs imm[11:5]=0000000 -> SLL.
  - 101 with imm[11:5]=0000000 -> SRL; with 0100000 -> SRA.
  - For shifts out_imm = {27'b0, instr[24:20]}.
- LUI (0110111): ADD, rs1=0, imm = {instr[31:12],12'b0}, use_imm=1.
- AUIPC (0010111): same as LUI plus use_pc=1.
- Illegal:
  - Any other opcode, instr[1:0]!=2'b11, or a bad funct7/shift field.
  - Payload still issues with out_valid=1 and out_illegal=1.
  - out_alu_control=0000, out_reg_write=0, out_imm=0.
- rd==0: decoded normally, out_reg_write=0.

Decomposition:
- Package rv32i_pkg holds:
  - ALU operation code constants (shared with the ALU).
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - funct7 constants F7_BASE=7'b0000000, F7_ALT=7'b0100000.
  - A packed decode-bundle struct.
- One sub-module, rv32i_alu_decoder: purely combinational instruction -> bundle.
- The stage wraps rv32i_alu_decoder with the handshake register and flush logic.

Test Plan:
- Reset, then 0x002081B3 (add x3,x1,x2) with out_ready=1:
  - Cycle+1: out_valid=1, alu=0000, rs1=1, rs2=2, rd=3, use_imm=0, reg_write=1.
- 0x407302B3 (sub x5,x6,x7), then 0x40315093 (srai x1,x2,3) back-to-back:
  - First: alu=0001, rs1=6, rs2=7, rd=5.
  - Second: alu=0111, imm=3, use_imm=1.
- 0xFFF00093 (addi x1,x0,-1) and 0x12345137 (lui x2,0x12345):
  - addi: imm=0xFFFFFFFF.
  - lui: imm=0x12345000, rs1=0, alu=0000.
- 0x40001093 (slli with funct7=0100000) and 0x00000000:
  - Both: out_illegal=1, reg_write=0, alu=0000.
- Hold out_ready=0 for 3 cycles with a valid payload and in_valid=1:
  - in_ready=0 and payload stable for those cycles.
  - Raising out_ready gives the same-edge handoff: the next instruction appears the following cycle.
- Assert flush while holding a stalled payload and presenting a new instruction:
  - Next cycle out_valid=0; neither instruction appears later.
- Assert rst mid-stream: out_valid=0 and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I ALU decode constants and decode bundle type
//
// Purpose: ALU operation codes (shared with the execute-stage ALU), the
// ALU-class major opcodes, funct7 qualifiers and the packed decode bundle
// that travels from the decoder into the decode-stage pipeline register.
// Ports: none (package).

package rv32i_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_op_e     alu_control;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        use_pc;
      logic        reg_write;
      logic        illegal;
   } decode_t;

   // I-type immediate, sign-extended from instr[31].
   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   // U-type immediate: upper 20 bits, low 12 bits zero.
   function automatic logic [31:0] imm_u(input logic [31:0] instr);
      return {instr[31:12], 12'b0};
   endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// rtl/rv32i_alu_decoder.sv - combinational RV32I ALU-class instruction decoder
//
// Purpose: turns one raw instruction word into a decode bundle.
// Ports:
//   instr  in   32  raw instruction word
//   dec    out  decode_t  decoded ALU controls; illegal forms come out with
//                 alu_control=ADD, imm=0, no operand selects, reg_write=0

module rv32i_alu_decoder
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   output decode_t     dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   decode_t    d;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      d             = '0;
      d.rs1         = instr[19:15];
      d.rs2         = instr[24:20];
      d.rd          = instr[11:7];
      d.alu_control = ALU_ADD;
      d.illegal     = 1'b1;

      // Opcode compare covers instr[1:0]==2'b11: every ALU-class opcode ends in 11.
      case (opcode)
         OPC_OP: begin
            d.illegal = 1'b0;
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_BASE)     d.alu_control = ALU_ADD;
                  else if (funct7 == F7_ALT) d.alu_control = ALU_SUB;
                  else                       d.illegal     = 1'b1;
               end
               3'b001: begin
                  d.alu_control = ALU_SLL;
                  d.illegal     = (funct7 != F7_BASE);
               end
               3'b010: begin
                  d.alu_control = ALU_SLT;
                  d.illegal     = (funct7 != F7_BASE);
               end
               3'b011: begin
                  d.alu_control = ALU_SLTU;
                  d.illegal     = (funct7 != F7_BASE);
               end
               3'b100: begin
                  d.alu_control = ALU_XOR;
                  d.illegal     = (funct7 != F7_BASE);
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     d.alu_control = ALU_SRL;
                  else if (funct7 == F7_ALT) d.alu_control = ALU_SRA;
                  else                       d.illegal     = 1'b1;
               end
               3'b110: begin
                  d.alu_control = ALU_OR;
                  d.illegal     = (funct7 != F7_BASE);
               end
               default: begin
                  d.alu_control = ALU_AND;
                  d.illegal     = (funct7 != F7_BASE);
               end
            endcase
         end

         OPC_OP_IMM: begin
            d.illegal = 1'b0;
            d.use_imm = 1'b1;
            d.rs2     = 5'd0;
            d.imm     = imm_i(instr);
            case (funct3)
               3'b000: d.alu_control = ALU_ADD;
               3'b010: d.alu_control = ALU_SLT;
               3'b011: d.alu_control = ALU_SLTU;
               3'b100: d.alu_control = ALU_XOR;
               3'b110: d.alu_control = ALU_OR;
               3'b111: d.alu_control = ALU_AND;
               3'b001: begin
                  // imm[11:5] doubles as the shift funct7 field.
                  d.alu_control = ALU_SLL;
                  d.imm         = {27'b0, instr[24:20]};
                  d.illegal     = (funct7 != F7_BASE);
               end
               default: begin
                  d.imm = {27'b0, instr[24:20]};
                  if (funct7 == F7_BASE)     d.alu_control = ALU_SRL;
                  else if (funct7 == F7_ALT) d.alu_control = ALU_SRA;
                  else                       d.illegal     = 1'b1;
               end
            endcase
         end

         OPC_LUI, OPC_AUIPC: begin
            d.illegal     = 1'b0;
            d.alu_control = ALU_ADD;
            d.rs1         = 5'd0;
            d.rs2         = 5'd0;
            d.imm         = imm_u(instr);
            d.use_imm     = 1'b1;
            d.use_pc      = (opcode == OPC_AUIPC);
         end

         default: d.illegal = 1'b1;
      endcase

      // Illegal words still issue, but with neutral ALU controls so EX does nothing harmful.
      if (d.illegal) begin
         d.alu_control = ALU_ADD;
         d.imm         = '0;
         d.use_imm     = 1'b0;
         d.use_pc      = 1'b0;
      end

      d.reg_write = !d.illegal && (d.rd != 5'd0);
      dec         = d;
   end

endmodule

// File: rtl/rv32i_alu_decode_stage.sv
// rtl/rv32i_alu_decode_stage.sv - registered RV32I ALU decode stage with handshake
//
// Purpose: accepts fetched instructions over valid/ready, decodes them with
// rv32i_alu_decoder and holds one EX payload register with back-pressure
// and flush.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               drop held payload and the instruction offered this cycle
//   in_valid/in_ready   fetch-side handshake; in_instr, in_pc payload
//   out_valid/out_ready EX-side handshake
//   out_alu_control, out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
//   out_use_pc, out_reg_write, out_pc, out_illegal   registered EX controls

module rv32i_alu_decode_stage
   import rv32i_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_control,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_use_imm,
   output logic            out_use_pc,
   output logic            out_reg_write,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   decode_t         dec;
   logic            accept;

   logic            valid_d, valid_q;
   decode_t         payload_d, payload_q;
   logic [XLEN-1:0] pc_d, pc_q;

   rv32i_alu_decoder u_decoder (
      .instr (in_instr),
      .dec   (dec)
   );

   // Ready ignores flush so the handshake stays purely combinational on state.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      pc_d      = pc_q;

      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         payload_d = dec;
         pc_d      = in_pc;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         pc_q      <= RESET_PC_TAG;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         pc_q      <= pc_d;
      end
   end

   assign out_valid       = valid_q;
   assign out_alu_control = payload_q.alu_control;
   assign out_rs1         = payload_q.rs1;
   assign out_rs2         = payload_q.rs2;
   assign out_rd          = payload_q.rd;
   assign out_imm         = payload_q.imm;
   assign out_use_imm     = payload_q.use_imm;
   assign out_use_pc      = payload_q.use_pc;
   assign out_reg_write   = payload_q.reg_write;
   assign out_illegal     = payload_q.illegal;
   assign out_pc          = pc_q;

endmodule

// File: tb/tb_rv32i_alu_decode_stage.sv
// tb/tb_rv32i_alu_decode_stage.sv - self-checking bench for rv32i_alu_decode_stage

module tb_rv32i_alu_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_imm, out_pc;
   logic [3:0]  out_alu_control;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_use_imm, out_use_pc, out_reg_write, out_illegal;

   always #5 clk = ~clk;

   rv32i_alu_decode_stage dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .in_pc           (in_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_alu_control (out_alu_control),
      .out_rs1         (out_rs1),
      .out_rs2         (out_rs2),
      .out_rd          (out_rd),
      .out_imm         (out_imm),
      .out_use_imm     (out_use_imm),
      .out_use_pc      (out_use_pc),
      .out_reg_write   (out_reg_write),
      .out_pc          (out_pc),
      .out_illegal     (out_illegal)
   );

   typedef struct {
      logic [3:0]  alu;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        use_imm, use_pc, reg_write, illegal;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;

   logic        m_valid;
   exp_t        m_e;
   logic [31:0] m_pc;

   // funct3 -> base ALU code, one nibble per funct3 (funct3=0 in the low nibble).
   // The alternate funct7 forms (SUB, SRA) are always base code + 1.
   logic [31:0] alu_by_f3 = 32'h2364_9850;

   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t       e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      e.alu = 4'd0; e.imm = 32'd0; e.use_imm = 1'b0; e.use_pc = 1'b0;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.illegal = 1'b1;
      if (op == 7'h33) begin
         e.alu = alu_by_f3[f3*4 +: 4];
         if (f7 == 7'h00) e.illegal = 1'b0;
         else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
            e.illegal = 1'b0;
            e.alu     = e.alu + 4'd1;
         end
      end else if (op == 7'h13) begin
         e.alu     = alu_by_f3[f3*4 +: 4];
         e.imm     = 32'($signed(ins) >>> 20);
         e.use_imm = 1'b1;
         e.rs2     = 5'd0;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.imm = (ins >> 20) & 32'd31;
            if (f7 == 7'h00) e.illegal = 1'b0;
            else if (f7 == 7'h20 && f3 == 3'd5) begin
               e.illegal = 1'b0;
               e.alu     = e.alu + 4'd1;
            end
         end else begin
            e.illegal = 1'b0;
         end
      end else if (op == 7'h37 || op == 7'h17) begin
         e.illegal = 1'b0;
         e.alu     = 4'd0;
         e.rs1     = 5'd0;
         e.rs2     = 5'd0;
         e.imm     = ins & 32'hFFFF_F000;
         e.use_imm = 1'b1;
         e.use_pc  = (op == 7'h17);
      end
      if (e.illegal) begin
         e.alu = 4'd0; e.imm = 32'd0; e.use_imm = 1'b0; e.use_pc = 1'b0;
      end
      e.reg_write = !e.illegal && (e.rd != 5'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_payload(input string tag, input exp_t e, input logic [31:0] pc);
      chk({tag, " alu"},       32'(out_alu_control), 32'(e.alu));
      chk({tag, " imm"},       out_imm,              e.imm);
      chk({tag, " reg_write"}, 32'(out_reg_write),   32'(e.reg_write));
      chk({tag, " illegal"},   32'(out_illegal),     32'(e.illegal));
      chk({tag, " pc"},        out_pc,               pc);
      if (!e.illegal) begin
         chk({tag, " rs1"},     32'(out_rs1),     32'(e.rs1));
         chk({tag, " rs2"},     32'(out_rs2),     32'(e.rs2));
         chk({tag, " rd"},      32'(out_rd),      32'(e.rd));
         chk({tag, " use_imm"}, 32'(out_use_imm), 32'(e.use_imm));
         chk({tag, " use_pc"},  32'(out_use_pc),  32'(e.use_pc));
      end
   endtask

   task automatic check_reset();
      chk("rst valid",     32'(out_valid),       32'd0);
      chk("rst alu",       32'(out_alu_control), 32'd0);
      chk("rst rs1",       32'(out_rs1),         32'd0);
      chk("rst rs2",       32'(out_rs2),         32'd0);
      chk("rst rd",        32'(out_rd),          32'd0);
      chk("rst imm",       out_imm,              32'd0);
      chk("rst use_imm",   32'(out_use_imm),     32'd0);
      chk("rst use_pc",    32'(out_use_pc),      32'd0);
      chk("rst reg_write", 32'(out_reg_write),   32'd0);
      chk("rst illegal",   32'(out_illegal),     32'd0);
      chk("rst pc",        out_pc,               32'd0);
   endtask

   // One clock: drive at negedge, update the stage model at posedge, check at next negedge.
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rs);
      in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
      #1;
      if (!rs) chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
      @(posedge clk);
      if (rs) begin
         m_valid = 1'b0;
      end else if (fl) begin
         m_valid = 1'b0;
      end else if (iv && (!m_valid || ordy)) begin
         m_valid = 1'b1;
         m_e     = ref_decode(ins);
         m_pc    = pc;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      if (rs) check_reset();
      else begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) check_payload("model", m_e, m_pc);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] alu,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] imm, input logic ui, input logic up,
                               input logic rw, input logic ill);
      vec_t v;
      v.instr = instr;
      v.e.alu = alu; v.e.rs1 = rs1; v.e.rs2 = rs2; v.e.rd = rd; v.e.imm = imm;
      v.e.use_imm = ui; v.e.use_pc = up; v.e.reg_write = rw; v.e.illegal = ill;
      return v;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         default: f7 = r[31:25];
      endcase
      case ($urandom_range(0, 5))
         0, 1: return {f7, r[24:7], 7'b0110011};
         2, 3: return {f7, r[24:7], 7'b0010011};
         4: return {r[31:7], ($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b0010111};
         default: return r;
      endcase
   endfunction

   vec_t vecs[12];

   initial begin
      vecs[0]  = mk(32'h002081B3, 4'h0, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
      vecs[1]  = mk(32'h407302B3, 4'h1, 5'd6, 5'd7, 5'd5, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
      vecs[2]  = mk(32'h40315093, 4'h7, 5'd2, 5'd0, 5'd1, 32'h3,        1'b1, 1'b0, 1'b1, 1'b0);
      vecs[3]  = mk(32'hFFF00093, 4'h0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[4]  = mk(32'h12345137, 4'h0, 5'd0, 5'd0, 5'd2, 32'h12345000, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[5]  = mk(32'h40001093, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
      vecs[6]  = mk(32'h00000000, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
      vecs[7]  = mk(32'h00001097, 4'h0, 5'd0, 5'd0, 5'd1, 32'h00001000, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[8]  = mk(32'h00000013, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(32'hFFE33293, 4'h9, 5'd6, 5'd0, 5'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[10] = mk(32'h022081B3, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
      vecs[11] = mk(32'h002081B1, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);

      m_valid = 1'b0;
      m_e     = ref_decode(32'h0);
      m_pc    = 32'h0;

      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

      // Directed vectors, back-to-back with EX always ready.
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
         check_payload("vec", vecs[i].e, 32'h1000 + 32'(i * 4));
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Stall: payload held three cycles, then same-edge handoff.
      cycle(1'b1, 32'h002081B3, 32'h200, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h407302B3, 32'h204, 1'b0, 1'b0, 1'b0);
         chk("stall in_ready", 32'(in_ready), 32'd0);
         chk("stall rd",       32'(out_rd),   32'd3);
         chk("stall pc",       out_pc,        32'h200);
      end
      cycle(1'b1, 32'h407302B3, 32'h204, 1'b1, 1'b0, 1'b0);
      chk("handoff rd",  32'(out_rd),          32'd5);
      chk("handoff alu", 32'(out_alu_control), 32'd1);

      // Flush while stalled with a new instruction offered: both vanish.
      cycle(1'b1, 32'h12345137, 32'h208, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h12345137, 32'h208, 1'b0, 1'b1, 1'b0);
      chk("flush valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         chk("post-flush valid", 32'(out_valid), 32'd0);
      end

      // Reset mid-stream discards an in-flight payload.
      cycle(1'b1, 32'hFFF00093, 32'h300, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h002081B3, 32'h304, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("post-rst valid", 32'(out_valid), 32'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 3) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 63) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
